// File: rtl/multi_timer.sv
// multi_timer: CHANNELS independent down-counting timers on the Peribus.
// Each channel has a prescaler, one-shot or auto-reload mode, a sticky
// write-1-to-clear expiry flag and an interrupt enable. irq ORs all enabled
// flags. Defining MULTI_TIMER_PWM_EN adds per-channel COMPARE registers and
// the registered pwm_out port.
//
// Bus handshake: a cycle with chipselect & write_en commits write_data to
// addr = {channel, reg[2:0]} on the next rising edge; a cycle with
// chipselect & read_en loads read_data on the next rising edge, and
// read_data holds its value in every other cycle. There is no stall.
module multi_timer #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int PRE_BITS = 8,
    parameter int ADDR_W   = $clog2(CHANNELS) + 3
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                write_en,
    input  logic [15:0]         write_data,
    input  logic                read_en,
    output logic [15:0]         read_data,
    output logic                irq
`ifdef MULTI_TIMER_PWM_EN
    ,
    output logic [CHANNELS-1:0] pwm_out
`endif
);

    // Per-channel state
    logic [WIDTH-1:0]    count_q     [CHANNELS];
    logic [WIDTH-1:0]    period_q    [CHANNELS];
    logic [PRE_BITS-1:0] prescale_q  [CHANNELS];
    logic [PRE_BITS-1:0] pre_count_q [CHANNELS];
    logic [CHANNELS-1:0] run_q;
    logic [CHANNELS-1:0] reload_q;
    logic [CHANNELS-1:0] irq_en_q;
    logic [CHANNELS-1:0] flag_q;
`ifdef MULTI_TIMER_PWM_EN
    logic [WIDTH-1:0]    compare_q   [CHANNELS];
    logic [CHANNELS-1:0] pwm_en_q;
    logic [CHANNELS-1:0] pwm_q;
`endif

    // Decoded bus and per-channel event strobes
    logic [31:0]         ch_sel;
    logic [2:0]          reg_sel;
    logic [CHANNELS-1:0] wr_count;
    logic [CHANNELS-1:0] wr_period;
    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] wr_status;
    logic [CHANNELS-1:0] wr_cmp;
    logic [CHANNELS-1:0] tick;
    logic [CHANNELS-1:0] expire;
    logic [15:0]         rd_val;

    // Not every write_data bit maps onto a register field.
    logic unused_wdata;
    assign unused_wdata = ^write_data;

    // Channel index is everything above the 3-bit register field; indices
    // past CHANNELS simply match no channel, so they read 0 and drop writes.
    assign ch_sel  = 32'(addr >> 3);
    assign reg_sel = addr[2:0];

    // Decode writes per channel and derive prescaler ticks and expiries.
    // A COUNT write in a tick cycle suppresses the expiry entirely.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wr_count[i]  = chipselect && write_en && (ch_sel == 32'(i)) && (reg_sel == 3'd0);
            wr_period[i] = chipselect && write_en && (ch_sel == 32'(i)) && (reg_sel == 3'd1);
            wr_ctrl[i]   = chipselect && write_en && (ch_sel == 32'(i)) && (reg_sel == 3'd2);
            wr_status[i] = chipselect && write_en && (ch_sel == 32'(i)) && (reg_sel == 3'd3);
            wr_cmp[i]    = chipselect && write_en && (ch_sel == 32'(i)) && (reg_sel == 3'd4);
            tick[i]      = run_q[i] && (pre_count_q[i] == '0);
            expire[i]    = tick[i] && (count_q[i] == '0) && !wr_count[i];
        end
    end

    // Channel state: prescaler, counter, configuration, flag and pwm.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]     <= '0;
                period_q[i]    <= '0;
                prescale_q[i]  <= '0;
                pre_count_q[i] <= '0;
`ifdef MULTI_TIMER_PWM_EN
                compare_q[i]   <= '0;
`endif
            end
            run_q    <= '0;
            reload_q <= '0;
            irq_en_q <= '0;
            flag_q   <= '0;
`ifdef MULTI_TIMER_PWM_EN
            pwm_en_q <= '0;
            pwm_q    <= '0;
`endif
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                // Prescaler idles at 0 so the first tick lands in the first run cycle.
                if (!run_q[i]) begin
                    pre_count_q[i] <= '0;
                end else if (tick[i]) begin
                    pre_count_q[i] <= prescale_q[i];
                end else begin
                    pre_count_q[i] <= pre_count_q[i] - PRE_BITS'(1);
                end

                // Counter: bus write beats the tick; expiry reloads or parks at 0.
                if (wr_count[i]) begin
                    count_q[i] <= write_data[WIDTH-1:0];
                end else if (tick[i]) begin
                    if (count_q[i] != '0) begin
                        count_q[i] <= count_q[i] - WIDTH'(1);
                    end else if (reload_q[i]) begin
                        count_q[i] <= period_q[i];
                    end
                end

                if (wr_period[i]) begin
                    period_q[i] <= write_data[WIDTH-1:0];
                end

                // CONTROL write beats a one-shot auto-stop in the same cycle.
                if (wr_ctrl[i]) begin
                    run_q[i]      <= write_data[0];
                    reload_q[i]   <= write_data[1];
                    irq_en_q[i]   <= write_data[2];
                    prescale_q[i] <= write_data[8 +: PRE_BITS];
`ifdef MULTI_TIMER_PWM_EN
                    pwm_en_q[i]   <= write_data[3];
`endif
                end else if (expire[i] && !reload_q[i]) begin
                    run_q[i] <= 1'b0;
                end

                // Expiry set beats a simultaneous write-1-to-clear.
                if (expire[i]) begin
                    flag_q[i] <= 1'b1;
                end else if (wr_status[i] && write_data[1]) begin
                    flag_q[i] <= 1'b0;
                end

`ifdef MULTI_TIMER_PWM_EN
                if (wr_cmp[i]) begin
                    compare_q[i] <= write_data[WIDTH-1:0];
                end
                pwm_q[i] <= run_q[i] && pwm_en_q[i] && (count_q[i] < compare_q[i]);
`endif
            end
        end
    end

    // Read mux: zero-extended fields of the addressed channel register.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel == 32'(i)) begin
                case (reg_sel)
                    3'd0: rd_val[WIDTH-1:0] = count_q[i];
                    3'd1: rd_val[WIDTH-1:0] = period_q[i];
                    3'd2: begin
                        rd_val[8 +: PRE_BITS] = prescale_q[i];
`ifdef MULTI_TIMER_PWM_EN
                        rd_val[3] = pwm_en_q[i];
`endif
                        rd_val[2] = irq_en_q[i];
                        rd_val[1] = reload_q[i];
                        rd_val[0] = run_q[i];
                    end
                    3'd3: begin
                        rd_val[1] = flag_q[i];
                        rd_val[0] = run_q[i];
                    end
`ifdef MULTI_TIMER_PWM_EN
                    3'd4: rd_val[WIDTH-1:0] = compare_q[i];
`endif
                    default: rd_val = '0;
                endcase
            end
        end
    end

    // Registered read data, held between reads.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            read_data <= '0;
        end else if (chipselect && read_en) begin
            read_data <= rd_val;
        end
    end

    assign irq = |(flag_q & irq_en_q);

`ifdef MULTI_TIMER_PWM_EN
    assign pwm_out = pwm_q;
`else
    logic unused_cmp;
    assign unused_cmp = ^wr_cmp;
`endif

endmodule

// File: tb/tb_multi_timer.sv
// Testbench for multi_timer with five channels, so that channel indices 5-7
// exist on the bus but are unimplemented. A behavioural timer model tracks
// every register from the bus traffic and is checked each cycle against
// read_data, irq and (when built with MULTI_TIMER_PWM_EN) pwm_out; directed
// reads against literal values pin the model to the intended behaviour.
module tb_multi_timer;
    localparam int CH    = 5;
    localparam int W     = 16;
    localparam int PB    = 8;
    localparam int AW    = $clog2(CH) + 3;
    localparam int WMASK = (1 << W) - 1;
    localparam int PMASK = (1 << PB) - 1;

    logic          clock      = 1'b0;
    logic          reset_n    = 1'b0;
    logic          chipselect = 1'b0;
    logic          write_en   = 1'b0;
    logic          read_en    = 1'b0;
    logic [AW-1:0] addr       = '0;
    logic [15:0]   write_data = '0;
    logic [15:0]   read_data;
    logic          irq;
`ifdef MULTI_TIMER_PWM_EN
    logic [CH-1:0] pwm_out;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int bg_i     = 0;

    // Model state, one entry per channel
    int m_count [CH];
    int m_period[CH];
    int m_pre   [CH];
    int m_run   [CH];
    int m_reload[CH];
    int m_irqen [CH];
    int m_pwmen [CH];
    int m_cmp   [CH];
    int m_flag  [CH];
    int m_phase [CH];
    int m_pwm   [CH];
    int m_rd    = 0;
    int m_irq_v = 0;

    int found, t_prev, t_now, ones;

    multi_timer #(
        .CHANNELS(CH),
        .WIDTH   (W),
        .PRE_BITS(PB)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .chipselect(chipselect),
        .addr      (addr),
        .write_en  (write_en),
        .write_data(write_data),
        .read_en   (read_en),
        .read_data (read_data),
        .irq       (irq)
`ifdef MULTI_TIMER_PWM_EN
        ,
        .pwm_out   (pwm_out)
`endif
    );

    // Clock and cycle counter
    always #5 clock = ~clock;

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_checks++;
        if (act !== 32'(exp)) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register value the model expects at address a.
    function automatic int m_reg(input int a);
        int ch, r;
        ch = a >> 3;
        r  = a & 7;
        if (ch >= CH) return 0;
        case (r)
            0: return m_count[ch];
            1: return m_period[ch];
            2: return (m_pre[ch] << 8) | (m_pwmen[ch] << 3) | (m_irqen[ch] << 2) |
                      (m_reload[ch] << 1) | m_run[ch];
            3: return (m_flag[ch] << 1) | m_run[ch];
            4: return m_cmp[ch];
            default: return 0;
        endcase
    endfunction

    // One clock of the timer rules. The prescaler is modelled as the number
    // of cycles spent running: a tick falls on every multiple of prescale+1.
    task automatic model_step();
        int a, r, ch, wd;
        bit wr, hit, tk, expire, was_run;
        if (!reset_n) begin
            for (int i = 0; i < CH; i++) begin
                m_count[i] = 0; m_period[i] = 0; m_pre[i] = 0; m_run[i] = 0;
                m_reload[i] = 0; m_irqen[i] = 0; m_pwmen[i] = 0; m_cmp[i] = 0;
                m_flag[i] = 0; m_phase[i] = 0; m_pwm[i] = 0;
            end
            m_rd = 0;
            return;
        end
        a  = int'(addr);
        ch = a >> 3;
        r  = a & 7;
        wd = int'(write_data);
        wr = chipselect && write_en;
        if (chipselect && read_en) m_rd = m_reg(a);
        for (int i = 0; i < CH; i++) begin
            hit     = wr && (ch == i);
            tk      = (m_run[i] != 0) && ((m_phase[i] % (m_pre[i] + 1)) == 0);
            expire  = tk && (m_count[i] == 0) && !(hit && r == 0);
            was_run = (m_run[i] != 0);
            m_pwm[i] = (m_run[i] != 0 && m_pwmen[i] != 0 && m_count[i] < m_cmp[i]) ? 1 : 0;
            if (hit && r == 0) m_count[i] = wd & WMASK;
            else if (expire) begin
                m_flag[i] = 1;
                if (m_reload[i] != 0) m_count[i] = m_period[i];
                else m_run[i] = 0;
            end else if (tk) m_count[i] = m_count[i] - 1;
            if (hit && r == 1) m_period[i] = wd & WMASK;
            if (hit && r == 2) begin
                m_run[i]    = wd & 1;
                m_reload[i] = (wd >> 1) & 1;
                m_irqen[i]  = (wd >> 2) & 1;
                m_pre[i]    = (wd >> 8) & PMASK;
`ifdef MULTI_TIMER_PWM_EN
                m_pwmen[i]  = (wd >> 3) & 1;
`endif
            end
            if (hit && r == 3 && (wd & 2) != 0 && !expire) m_flag[i] = 0;
`ifdef MULTI_TIMER_PWM_EN
            if (hit && r == 4) m_cmp[i] = wd & WMASK;
`endif
            m_phase[i] = was_run ? m_phase[i] + 1 : 0;
        end
    endtask

    initial forever begin
        @(posedge clock or negedge reset_n);
        model_step();
    end

    // Scoreboard compare on every falling edge while out of reset.
    initial forever begin
        @(negedge clock);
        if (reset_n) begin
            m_irq_v = 0;
            for (int i = 0; i < CH; i++)
                if (m_flag[i] != 0 && m_irqen[i] != 0) m_irq_v = 1;
            chk("read_data", read_data, m_rd);
            chk("irq", irq, m_irq_v);
`ifdef MULTI_TIMER_PWM_EN
            for (int i = 0; i < CH; i++) chk("pwm_out", pwm_out[i], m_pwm[i]);
`endif
        end
    end

    // Driver tasks: each occupies exactly one bus cycle.
    task automatic wr(input int a, input int d);
        chipselect = 1'b1; write_en = 1'b1; read_en = 1'b0;
        addr = AW'(a); write_data = 16'(d);
        @(negedge clock);
    endtask

    task automatic rd(input int a);
        chipselect = 1'b1; write_en = 1'b0; read_en = 1'b1;
        addr = AW'(a);
        @(negedge clock);
    endtask

    task automatic rd_chk(input int a, input int exp, input string name);
        rd(a);
        chk(name, read_data, exp);
    endtask

    // Idle cycles still read, cycling through COUNT/STATUS of every channel.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            chipselect = 1'b1; write_en = 1'b0; read_en = 1'b1;
            addr = AW'(((bg_i >> 1) << 3) | (((bg_i & 1) != 0) ? 3 : 0));
            bg_i = (bg_i + 1) % 10;
            @(negedge clock);
        end
    endtask

    initial begin
        // Reset
        repeat (3) @(negedge clock);
        chk("rst_read_data", read_data, 0);
        chk("rst_irq", irq, 0);
        reset_n = 1'b1;
        idle(2);

        // One-shot on ch0: count 3,2,1,0, expiry on the 4th tick
        wr(0, 3);
        wr(2, 16'h0005);
        for (int k = 0; k < 4; k++) rd_chk(0, 3 - k, "os_count_seq");
        rd_chk(3, 16'h0002, "os_status");
        chk("os_irq", irq, 1);
        rd_chk(2, 16'h0004, "os_control_run_cleared");
        rd_chk(0, 0, "os_count_zero");
        wr(3, 16'h0002);
        chk("os_irq_clear", irq, 0);
        idle(3);

        // Auto-reload on ch2, prescale 1, period 4: expiry every 10 cycles
        wr(17, 4);
        wr(16, 0);
        wr(18, 16'h0103);
        idle(25);
        rd_chk(19, 16'h0003, "ar_flag_sticky");
        chk("ar_irq_masked", irq, 0);
        wr(19, 16'h0002);
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            found = 0;
            for (int j = 0; j < 40 && found == 0; j++) begin
                rd(19);
                if (read_data[1]) found = 1;
            end
            t_now = cyc;
            chk("ar_expiry_seen", found, 1);
            wr(19, 16'h0002);
            if (k >= 2) chk("ar_interval", t_now - t_prev, 10);
            t_prev = t_now;
        end
        wr(18, 16'h0100);
        idle(3);

        // Simultaneous events on ch1 (expiry lands 3 cycles after start)
        wr(8, 2);
        wr(10, 16'h0001);
        idle(2);
        wr(11, 16'h0002);
        rd_chk(11, 16'h0002, "sim_w1c_set_wins");
        wr(11, 16'h0002);
        rd_chk(11, 0, "sim_flag_cleared");
        wr(8, 2);
        wr(10, 16'h0001);
        idle(2);
        wr(8, 7);
        rd_chk(8, 7, "sim_count_write_wins");
        rd_chk(11, 16'h0001, "sim_no_flag_still_running");
        wr(10, 0);
        idle(2);

        // Multi-channel irq, reserved and unimplemented addresses
        wr(0, 1);
        wr(2, 16'h0005);
        wr(24, 1);
        wr(26, 16'h0005);
        idle(4);
        chk("mc_irq_both", irq, 1);
        wr(3, 16'h0002);
        chk("mc_irq_ch3_left", irq, 1);
        wr(27, 16'h0002);
        chk("mc_irq_none", irq, 0);
        wr(6, 16'hFFFF);
        rd_chk(6, 0, "reserved_reg6");
        wr(40, 16'h1234);
        rd_chk(40, 0, "bad_channel_count");
        rd_chk(59, 0, "bad_channel_status");
        wr(34, 16'h0F0E);
`ifdef MULTI_TIMER_PWM_EN
        rd_chk(34, 16'h0F0E, "ctrl_readback");
`else
        rd_chk(34, 16'h0F06, "ctrl_readback");
`endif
        wr(36, 5);
`ifdef MULTI_TIMER_PWM_EN
        rd_chk(36, 5, "compare_readback");
`else
        rd_chk(36, 0, "compare_readback");
`endif
        wr(34, 0);
        idle(2);

`ifdef MULTI_TIMER_PWM_EN
        // PWM on ch1: period 9, compare 3 -> high 3 of every 10 cycles
        wr(9, 9);
        wr(12, 3);
        wr(8, 0);
        wr(10, 16'h000B);
        idle(12);
        ones = 0;
        for (int k = 0; k < 30; k++) begin
            idle(1);
            if (pwm_out[1]) ones++;
        end
        chk("pwm_duty", ones, 9);
        wr(12, 0);
        idle(2);
        ones = 0;
        for (int k = 0; k < 20; k++) begin
            idle(1);
            if (pwm_out[1]) ones++;
        end
        chk("pwm_compare0_low", ones, 0);
        wr(12, 3);
        idle(3);
`endif

        // Asynchronous reset while ch0 runs with irq asserted
        wr(1, 5);
        wr(0, 1);
        wr(2, 16'h0007);
        idle(4);
        chk("pre_reset_irq", irq, 1);
        rd_chk(1, 5, "pre_reset_period");
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_irq", irq, 0);
        chk("async_rst_read_data", read_data, 0);
`ifdef MULTI_TIMER_PWM_EN
        chk("async_rst_pwm", pwm_out, 0);
`endif
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        rd_chk(0, 0, "post_rst_count");
        rd_chk(1, 0, "post_rst_period");
        rd_chk(2, 0, "post_rst_control");
        rd_chk(3, 0, "post_rst_status");
        rd_chk(18, 0, "post_rst_ch2_control");
        idle(5);
        chk("post_rst_irq", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parameterised multi-channel down-counting timer on the Peribus, generalising the single 16-bit timer. Provides `CHANNELS` independent timers of `WIDTH` bits, each with its own prescaler, one-shot or auto-reload mode, a sticky write-1-to-clear interrupt flag and an interrupt enable. A single `irq` output ORs all enabled channel flags. An optional per-channel PWM compare output is compiled in with a macro.

## Interface
- `CHANNELS`, 4: number of timer channels (1..16).
- `WIDTH`, 16: counter/period/compare width (1..16). Read data is zero-extended to 16 bits; write data is truncated to `WIDTH`.
- `PRE_BITS`, 8: prescaler width (1..8).
- `ADDR_W`, `$clog2(CHANNELS)+3` (derived, min 3): bus address width.
- `clock` in 1: system clock, all state updates on the rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `chipselect` in 1: peripheral select.
- `addr` in ADDR_W: `{channel, reg[2:0]}`.
- `write_en` in 1: write strobe, qualified by `chipselect`.
- `write_data` in 16: write data.
- `read_en` in 1: read strobe, qualified by `chipselect`.
- `read_data` out 16: registered read data.
- `irq` out 1: `|(flag[n] & irq_en[n])`, combinational from registers.
- `pwm_out` out CHANNELS: present only with `MULTI_TIMER_PWM_EN`.

## Operation
- Per-channel register map (reg field):
  - 0 COUNT: RW.
  - 1 PERIOD: RW.
  - 2 CONTROL: `{prescale[15:8], 4'h0, pwm_en[3], irq_en[2], reload[1], run[0]}`. Prescale bits above `PRE_BITS` read 0.
  - 3 STATUS: `{14'h0, flag[1], running[0]}`. `running` is a read-only mirror of `run`. Writing 1 to bit 1 clears `flag`.
  - 4 COMPARE: RW with the macro defined, otherwise reads 0 and ignores writes.
  - 5-7 reserved: read 0, writes ignored.
- Channel indices at or above `CHANNELS` read 0 and ignore writes.
- Prescaler: `pre_count` is forced to 0 while `run` = 0. With `run` = 1:
  - if `pre_count` = 0: emit a tick and reload `pre_count` with `prescale`;
  - otherwise decrement `pre_count`.
  - Ticks therefore occur every `prescale+1` cycles, the first one in the first cycle `run` = 1.
- On a tick:
  - if `count` != 0: `count` <= `count`-1;
  - if `count` = 0 (expiry): set `flag`. If `reload` = 1, `count` <= `period`. If `reload` = 0, `count` stays 0 and `run` clears.
- An auto-reload period of P gives an expiry every (P+1) ticks. P = 0 expires on every tick.
- Simultaneous events:
  - A bus write to COUNT in a tick cycle wins: the write value is loaded and any decrement or expiry (including the flag set) is discarded.
  - A bus write to CONTROL in the same cycle as a one-shot auto-stop wins.
  - A W1C of `flag` in the same cycle as an expiry: the set wins and `flag` stays 1.
  - A STATUS write never alters `running`.

## Timing
- Read latency is 1 cycle. `read_data` updates only in cycles with `chipselect & read_en` and otherwise holds.
- Write effects are visible on the next edge. A read issued in the cycle after a write returns the new value.
- `irq` rises in the cycle after the expiry edge (once `flag` = 1 and `irq_en` = 1) and falls in the cycle after the W1C or `irq_en` clear.
- Reset values: `read_data` 0, `irq` 0, `pwm_out` 0. All COUNT, PERIOD, CONTROL, STATUS, COMPARE and `pre_count` registers are 0.
- Reset asserted mid-count takes effect immediately (asynchronous) and the channels restart stopped.

## Configuration
- `MULTI_TIMER_PWM_EN` defined:
  - COMPARE registers and port `pwm_out` exist.
  - `pwm_out[n]` is registered: `pwm_out[n]` <= `run & pwm_en & (count < compare)`, one cycle behind `count`.
  - `compare` = 0 gives a constant 0; `compare` > `period` gives a constant 1 while running.
- Undefined: no COMPARE storage, no `pwm_out` port, and `pwm_en` is read as 0.

## Test plan
- One-shot: ch0 COUNT=3, CONTROL=0x0005 (run, irq_en, prescale 0).
  - Required: count goes 3,2,1,0; expiry on the 4th tick; `flag`=1; `irq`=1; `run`=0; COUNT reads 0.
  - Then write STATUS=0x0002: `irq` drops 1 cycle later.
- Auto-reload with prescale: ch2 PERIOD=4, COUNT=0, CONTROL=0x0103 (prescale 1).
  - Required: expiries exactly every 10 cycles; `flag` sticky; `irq` stays 0 (`irq_en`=0).
- Simultaneous events: in the exact cycle of a ch1 expiry, (a) write STATUS=0x0002, then flag must remain 1; (b) separately, write COUNT=7, then COUNT reads 7 and `flag` must stay 0.
- Multi-channel IRQ: ch0 and ch3 expire with `irq_en`.
  - Clearing ch0 only keeps `irq`=1; clearing ch3 drops it.
  - Reads of reserved reg 6 and of channel index ≥ `CHANNELS` return 0.
- PWM (macro defined): ch1 PERIOD=9, COMPARE=3, CONTROL=0x000B.
  - Required: `pwm_out[1]` high 3 of every 10 cycles, lagging `count` by 1 cycle.
  - COMPARE=0 gives a constant low.
- Reset mid-run: assert `reset_n`=0 asynchronously while ch0 runs with `irq`=1.
  - Required: `irq`, `read_data` and `pwm_out` go 0 immediately; after release all registers read 0.
